// File: rtl/axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// axi4_lite_slave_regs : AXI4-Lite responder over NUM_REGS 32-bit registers;
// define AXIL_SLV_ADDR_CHECK_EN to answer out-of-range accesses with SLVERR.
// Revision 1.0
// ============================================================================
module axi4_lite_slave_regs #(
  parameter  int NUM_REGS = 8,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [31:0]              S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]   REG_OUT,
  output logic [NUM_REGS-1:0]      REG_WR_PULSE
);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  w_state_t    w_state;
  r_state_t    r_state;
  logic [31:0] regs [NUM_REGS];
  logic        aw_held, w_held;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;

  logic             aw_hs, w_hs, ar_hs, wr_commit, wr_err, rd_err;
  logic [31:0]      wr_addr, wr_data;
  logic [3:0]       wr_strb;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign S_AXI_AWREADY = (w_state == W_IDLE) && !aw_held;
  assign S_AXI_WREADY  = (w_state == W_IDLE) && !w_held;
  assign S_AXI_ARREADY = (r_state == R_IDLE);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A held beat takes priority; otherwise the beat arriving this cycle is used.
  assign wr_commit = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr   = aw_held ? aw_addr : S_AXI_AWADDR;
  assign wr_data   = w_held ? w_data : S_AXI_WDATA;
  assign wr_strb   = w_held ? w_strb : S_AXI_WSTRB;
  assign wr_idx    = wr_addr[IDX_W+1:2];
  assign rd_idx    = S_AXI_ARADDR[IDX_W+1:2];

`ifdef AXIL_SLV_ADDR_CHECK_EN
  assign wr_err = |wr_addr[31:IDX_W+2];
  assign rd_err = |S_AXI_ARADDR[31:IDX_W+2];
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[31:IDX_W+2], wr_addr[1:0],
                              S_AXI_ARADDR[31:IDX_W+2], S_AXI_ARADDR[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state      <= W_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr      <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      REG_WR_PULSE <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      REG_WR_PULSE <= '0;
      case (w_state)
        W_IDLE: begin
          if (wr_commit) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            w_state      <= W_RESP;
            if (!wr_err) begin
              REG_WR_PULSE[wr_idx] <= 1'b1;
              for (int k = 0; k < 4; k++)
                if (wr_strb[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
          end else begin
            if (aw_hs) begin
              aw_held <= 1'b1;
              aw_addr <= S_AXI_AWADDR;
            end
            if (w_hs) begin
              w_held <= 1'b1;
              w_data <= S_AXI_WDATA;
              w_strb <= S_AXI_WSTRB;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Nonblocking read of regs returns the pre-write value on a same-edge commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= R_IDLE;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            S_AXI_RDATA  <= rd_err ? 32'h0 : regs[rd_idx];
            S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            S_AXI_RVALID <= 1'b1;
            r_state      <= R_RESP;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign REG_OUT[32*i +: 32] = regs[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// tb_axi4_lite_slave_regs : directed stimulus with a B/R response scoreboard.
// Revision 1.0
// ============================================================================
module tb_axi4_lite_slave_regs;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  S_AXI_AWADDR = '0;
  logic         S_AXI_AWVALID = 1'b0;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA = '0;
  logic [3:0]   S_AXI_WSTRB = '0;
  logic         S_AXI_WVALID = 1'b0;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY = 1'b1;
  logic [31:0]  S_AXI_ARADDR = '0;
  logic         S_AXI_ARVALID = 1'b0;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY = 1'b1;
  logic [255:0] REG_OUT;
  logic [7:0]   REG_WR_PULSE;

  axi4_lite_slave_regs #(.NUM_REGS(8)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .REG_OUT(REG_OUT), .REG_WR_PULSE(REG_WR_PULSE)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] resp; logic [7:0] pulse; } b_exp_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_exp_t;

  b_exp_t      exp_b[$];
  r_exp_t      exp_r[$];
  logic [31:0] model [8];
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got timeout/unexpected event, required handshake", name);
  endtask

  function automatic logic addr_err(input logic [31:0] a);
`ifdef AXIL_SLV_ADDR_CHECK_EN
    return |a[31:5];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [255:0] packed_model();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  // Scoreboard monitor: pops on the first cycle of each response, then checks stability.
  logic       b_seen = 1'b0, r_seen = 1'b0;
  logic [1:0] b_lat, r_lat;
  logic [31:0] rd_lat;
  always @(negedge clk) begin
    if (rst) begin
      b_seen = 1'b0;
      r_seen = 1'b0;
    end else begin
      if (S_AXI_BVALID && !b_seen) begin
        b_exp_t be;
        b_seen = 1'b1;
        b_lat  = S_AXI_BRESP;
        if (exp_b.size() == 0) fail_now("b_unexpected");
        else begin
          be = exp_b.pop_front();
          chk("bresp", S_AXI_BRESP, be.resp);
          chk("wr_pulse", REG_WR_PULSE, be.pulse);
        end
      end else begin
        chk("pulse_idle", REG_WR_PULSE, 0);
        if (S_AXI_BVALID) chk("bresp_stable", S_AXI_BRESP, b_lat);
      end
      if (S_AXI_BVALID && S_AXI_BREADY) b_seen = 1'b0;

      if (S_AXI_RVALID && !r_seen) begin
        r_exp_t re;
        r_seen = 1'b1;
        r_lat  = S_AXI_RRESP;
        rd_lat = S_AXI_RDATA;
        if (exp_r.size() == 0) fail_now("r_unexpected");
        else begin
          re = exp_r.pop_front();
          chk("rdata", S_AXI_RDATA, re.data);
          chk("rresp", S_AXI_RRESP, re.resp);
        end
      end else if (S_AXI_RVALID) begin
        chk("rresp_stable", S_AXI_RRESP, r_lat);
        chk("rdata_stable", S_AXI_RDATA, rd_lat);
      end
      if (S_AXI_RVALID && S_AXI_RREADY) r_seen = 1'b0;
    end
  end

  // All drivers are entered just after a rising edge and return just after one.
  task automatic do_aw(input logic [31:0] addr, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (S_AXI_AWREADY) begin @(posedge clk); #1; S_AXI_AWVALID = 1'b0; return; end
    end
    S_AXI_AWVALID = 1'b0;
    fail_now("aw_timeout");
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (S_AXI_WREADY) begin @(posedge clk); #1; S_AXI_WVALID = 1'b0; return; end
    end
    S_AXI_WVALID = 1'b0;
    fail_now("w_timeout");
  endtask

  task automatic do_ar(input logic [31:0] addr);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (S_AXI_ARREADY) begin @(posedge clk); #1; S_AXI_ARVALID = 1'b0; return; end
    end
    S_AXI_ARVALID = 1'b0;
    fail_now("ar_timeout");
  endtask

  task automatic wait_b();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (S_AXI_BVALID && S_AXI_BREADY) begin @(posedge clk); #1; return; end
    end
    fail_now("b_timeout");
  endtask

  task automatic wait_r();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (S_AXI_RVALID && S_AXI_RREADY) begin @(posedge clk); #1; return; end
    end
    fail_now("r_timeout");
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int daw, input int dw);
    logic       err = addr_err(addr);
    logic [2:0] idx = addr[4:2];
    b_exp_t     be;
    be.resp  = err ? 2'b10 : 2'b00;
    be.pulse = err ? 8'h00 : (8'h01 << idx);
    exp_b.push_back(be);
    if (!err)
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
    fork
      do_aw(addr, daw);
      do_w(data, strb, dw);
    join
    chk("bvalid_after_commit", S_AXI_BVALID, 1);
    chk("reg_out", REG_OUT, packed_model());
  endtask

  task automatic push_r(input logic [31:0] addr);
    r_exp_t re;
    re.data = addr_err(addr) ? 32'h0 : model[addr[4:2]];
    re.resp = addr_err(addr) ? 2'b10 : 2'b00;
    exp_r.push_back(re);
  endtask

  task automatic rd(input logic [31:0] addr);
    push_r(addr);
    do_ar(addr);
    chk("rvalid_after_ar", S_AXI_RVALID, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_reg_out", REG_OUT, 0);
    chk("rst_pulse", REG_WR_PULSE, 0);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    @(posedge clk); #1;

    // AW and W in the same cycle
    wr(32'h1000_0004, 32'hDEADBEEF, 4'hF, 0, 0);
    wait_b();
`ifndef AXIL_SLV_ADDR_CHECK_EN
    chk("reg1_value", REG_OUT[63:32], 32'hDEADBEEF);
`endif

    // W three cycles ahead of AW
    fork
      wr(32'h0, 32'hA5A5A5A5, 4'hF, 3, 0);
      begin
        @(posedge clk); #1;
        repeat (2) begin
          @(negedge clk);
          chk("w_first_wready", S_AXI_WREADY, 0);
          chk("w_first_awready", S_AXI_AWREADY, 1);
          chk("w_first_no_commit", S_AXI_BVALID, 0);
        end
      end
    join
    wait_b();
    chk("reg0_value", REG_OUT[31:0], 32'hA5A5A5A5);

    // Partial strobe
    wr(32'h8, 32'h11223344, 4'hF, 0, 0);
    wait_b();
    wr(32'h8, 32'hFFFFFFFF, 4'h5, 0, 0);
    wait_b();
    chk("reg2_partial", REG_OUT[95:64], 32'h11FF33FF);
    rd(32'h8);
    wait_r();

    // AW ahead of W, zero strobe still pulses
    wr(32'h1C, 32'h12345678, 4'h0, 0, 2);
    wait_b();
    chk("reg7_unchanged", REG_OUT[255:224], 32'h0);

    // Response back-pressure
    S_AXI_BREADY = 1'b0;
    wr(32'hC, 32'h0BADC0DE, 4'hF, 0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_bvalid", S_AXI_BVALID, 1);
      chk("stall_aw_w_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
    end
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b1;
    wait_b();
    S_AXI_RREADY = 1'b0;
    rd(32'hC);
    repeat (5) begin
      @(negedge clk);
      chk("stall_rvalid", S_AXI_RVALID, 1);
      chk("stall_arready", S_AXI_ARREADY, 0);
    end
    @(posedge clk); #1;
    S_AXI_RREADY = 1'b1;
    wait_r();

    // Out-of-range address
    wr(32'h40, 32'hCAFEF00D, 4'hF, 0, 0);
    wait_b();
    rd(32'h40);
    wait_r();

    // Read and write commit to reg2 on the same edge: read sees old value
    push_r(32'h8);
    fork
      wr(32'h8, 32'h55667788, 4'hF, 0, 0);
      do_ar(32'h8);
    join
    fork
      wait_b();
      wait_r();
    join

    // Reset with RVALID pending and AW held
    S_AXI_RREADY = 1'b0;
    rd(32'h4);
    do_aw(32'hC, 0);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", S_AXI_RVALID, 0);
    chk("rst_mid_bvalid", S_AXI_BVALID, 0);
    chk("rst_mid_regs", REG_OUT, 0);
    exp_r.delete();
    exp_b.delete();
    for (int i = 0; i < 8; i++) model[i] = '0;
    S_AXI_RREADY = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_aw_dropped", S_AXI_AWREADY, 1);
    wr(32'h14, 32'h5A5A0F0F, 4'hF, 0, 0);
    wait_b();
    for (int i = 0; i < 8; i++) begin
      rd(32'(i * 4));
      wait_r();
    end

    repeat (2) @(posedge clk);
    chk("b_queue_drained", exp_b.size(), 0);
    chk("r_queue_drained", exp_r.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
